// File: rtl/time_of_day_counter_pkg.sv
// Shared widths, limits and encodings for the minutes/hours time-of-day stage.
package time_of_day_counter_pkg;

  localparam int MIN_W       = 6;
  localparam int HR_W        = 5;
  localparam int MINUTES_MAX = 59;
  localparam int HOURS_MAX   = 23;

  typedef enum logic {
    ALARM_IDLE = 1'b0,
    ALARM_RING = 1'b1
  } alarm_state_e;

  localparam logic TGT_TIME  = 1'b0;
  localparam logic TGT_ALARM = 1'b1;

endpackage

// File: rtl/time_of_day_counter_mod_n_counter.sv
// Wrap-around counter 0..MAX with synchronous load; wrap_o flags the increment that returns to 0.
module mod_n_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         wrap_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         at_max;

  assign at_max = (value_q == W'(MAX));
  assign wrap_o = inc_i & ~load_i & at_max;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i) begin
      value_d = at_max ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour minutes/hours counter with valid/ready time and alarm loads and a
// two-state alarm FSM that rings until ack, disable or a minute-tick timeout.
module time_of_day_counter
  import time_of_day_counter_pkg::*;
#(
  parameter int RING_TIMEOUT_MIN = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_min,
  input  logic            set_valid,
  input  logic            set_target,
  input  logic [HR_W-1:0] set_hours,
  input  logic [MIN_W-1:0] set_minutes,
  output logic            set_ready,
  output logic            set_error,
  input  logic            alarm_en,
  input  logic            alarm_ack,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0] hours,
  output logic            hour_pulse,
  output logic            day_rollover,
  output logic            alarm
);

  localparam int RING_W = 6;

  logic             set_ready_q, set_error_q, hour_pulse_q, day_rollover_q;
  logic [HR_W-1:0]  alarm_hr_q;
  logic [MIN_W-1:0] alarm_min_q;
  alarm_state_e     state_q, state_d;
  logic [RING_W-1:0] ring_q, ring_d;

  logic             accept, range_ok, time_load, tick_eff, min_wrap, hr_wrap, match;
  logic [MIN_W-1:0] min_val, next_min;
  logic [HR_W-1:0]  hr_val, next_hr;

  assign accept    = set_valid & set_ready_q;
  assign range_ok  = (set_hours <= HR_W'(HOURS_MAX)) && (set_minutes <= MIN_W'(MINUTES_MAX));
  assign time_load = accept & (set_target == TGT_TIME);
  // Any accepted time load, valid or not, swallows a coincident tick.
  assign tick_eff  = tick_min & ~time_load;

  mod_n_counter #(.W(MIN_W), .MAX(MINUTES_MAX)) u_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (tick_eff),
    .load_i    (time_load & range_ok),
    .load_val_i(set_minutes),
    .value_o   (min_val),
    .wrap_o    (min_wrap)
  );

  mod_n_counter #(.W(HR_W), .MAX(HOURS_MAX)) u_hr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (min_wrap),
    .load_i    (time_load & range_ok),
    .load_val_i(set_hours),
    .value_o   (hr_val),
    .wrap_o    (hr_wrap)
  );

  // Time the counters will show after this edge, used for the alarm match.
  assign next_min = min_wrap ? '0 : min_val + MIN_W'(1);
  assign next_hr  = hr_wrap ? '0 : (min_wrap ? hr_val + HR_W'(1) : hr_val);
  assign match    = tick_eff & alarm_en & (next_min == alarm_min_q) & (next_hr == alarm_hr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_ready_q    <= 1'b0;
      set_error_q    <= 1'b0;
      hour_pulse_q   <= 1'b0;
      day_rollover_q <= 1'b0;
      alarm_hr_q     <= '0;
      alarm_min_q    <= '0;
    end else begin
      set_ready_q    <= 1'b1;
      set_error_q    <= accept & ~range_ok;
      hour_pulse_q   <= min_wrap;
      day_rollover_q <= min_wrap & hr_wrap;
      if (accept && range_ok && (set_target == TGT_ALARM)) begin
        alarm_hr_q  <= set_hours;
        alarm_min_q <= set_minutes;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALARM_IDLE;
      ring_q  <= '0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
    end
  end

  // Exit conditions are checked before entry, so ack on the match cycle keeps IDLE.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    case (state_q)
      ALARM_IDLE: begin
        if (match && !alarm_ack) begin
          state_d = ALARM_RING;
          ring_d  = '0;
        end
      end
      ALARM_RING: begin
        if (alarm_ack || !alarm_en ||
            (tick_min && (ring_q == RING_W'(RING_TIMEOUT_MIN - 1)))) begin
          state_d = ALARM_IDLE;
          ring_d  = '0;
        end else if (tick_min) begin
          ring_d = ring_q + RING_W'(1);
        end
      end
      default: begin
        state_d = ALARM_IDLE;
        ring_d  = '0;
      end
    endcase
  end

  always_comb begin
    alarm = (state_q == ALARM_RING);
  end

  assign set_ready    = set_ready_q;
  assign set_error    = set_error_q;
  assign minutes      = min_val;
  assign hours        = hr_val;
  assign hour_pulse   = hour_pulse_q;
  assign day_rollover = day_rollover_q;

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Minutes/hours stage directly downstream of the seconds counter. Its minute tick input is driven by the seconds counter's one-cycle rollover pulse. It keeps 24-hour time (00:00–23:59), accepts time and alarm loads over a valid/ready handshake, and runs a small alarm state machine with acknowledge and auto-timeout. All outputs are registered.

## Interface
Parameters:
- RING_TIMEOUT_MIN, default 5: number of minute ticks after which a ringing alarm self-clears (range 1–63).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_min  in  1  one-cycle minute pulse from the seconds counter's rollover output.
- set_valid  in  1  load request.
- set_target  in  1  load destination: 0 = time, 1 = alarm.
- set_hours  in  5  hours to load.
- set_minutes  in  6  minutes to load.
- set_ready  out  1  load can be accepted.
- set_error  out  1  one-cycle pulse when a load is rejected as out of range.
- alarm_en  in  1  alarm enable (level).
- alarm_ack  in  1  user acknowledge (one or more cycles).
- minutes  out  6  current minutes, 0–59.
- hours  out  5  current hours, 0–23.
- hour_pulse  out  1  one-cycle pulse on a tick-driven minutes wrap from 59 to 0.
- day_rollover  out  1  one-cycle pulse on a tick-driven wrap from 23:59 to 00:00.
- alarm  out  1  high while the alarm FSM is in the RING state.

## Operation
- Reset state: minutes = 0, hours = 0, alarm register = 00:00, set_ready = 0, set_error = 0, hour_pulse = 0, day_rollover = 0, alarm = 0, FSM = IDLE, ring counter = 0.
- set_ready becomes 1 on the first clk edge after rst_n deasserts. It then stays 1, so the block accepts one load per cycle.
- A load is accepted when set_valid & set_ready are both 1.
- A load is valid only when set_hours ≤ 23 and set_minutes ≤ 59.
  - A valid load writes the target register (time or alarm).
  - An invalid load writes nothing and pulses set_error on the next cycle.
- Tick handling, when no time load is accepted in the same cycle:
  - minutes increments.
  - At 59, minutes wraps to 0, hours increments, and hour_pulse fires.
  - At 23:59, the time wraps to 00:00 and both hour_pulse and day_rollover fire.
- Accepted time load in the same cycle as tick_min: the load wins and the tick is dropped. No pulses fire. This applies to invalid time loads as well.
- Accepted alarm load in the same cycle as tick_min: both take effect.
- Alarm FSM:
  - IDLE → RING when alarm_en = 1 and a tick-driven update produces new time == alarm register. A time load never triggers the alarm. On entry to RING, the ring counter is cleared.
  - RING → IDLE on any of: alarm_ack = 1, alarm_en = 0, or the ring counter reaching RING_TIMEOUT_MIN.
  - In RING, each tick_min increments the ring counter.
  - alarm_ack while in IDLE has no effect.
  - The exit check takes priority over re-entry, so ack in the match cycle leaves the FSM in IDLE.
- Counter arithmetic stays within its width. Counters never pass through out-of-range values.

## Timing
- Registered update: tick_min at edge N gives new minutes/hours and pulses visible after edge N. This is one cycle of latency.
- set_error is visible after the edge following the accepting edge. It is high for exactly one cycle.
- alarm asserts in the same cycle that the matching time appears on minutes/hours. It deasserts the cycle after the ack, disable or timeout edge.
- Back-to-back tick_min on consecutive cycles: each pulse is counted. No tick is lost except in a collision with a time load.
- Reset mid-operation: all state clears immediately and asynchronously. A load pending in that cycle is discarded.

## Structure
- Shared package holds:
  - MINUTES_MAX = 59 and HOURS_MAX = 23.
  - Widths MIN_W = 6 and HR_W = 5.
  - The alarm state enum {ALARM_IDLE, ALARM_RING}.
  - The set_target encoding constants TGT_TIME and TGT_ALARM.
- One sub-module is natural: mod_n_counter, a parameterized wrap counter with inc, load, value and wrap outputs. It is instantiated for both minutes and hours.
- The alarm FSM and load handshake stay in the top module.

## Test plan
- Reset, then 60 tick_min pulses → minutes 0 → 59 → 0; hour_pulse fires once, with hours = 1 on the same cycle; day_rollover stays 0.
- Load 23:59 (set_target = 0), then one tick → 00:00; hour_pulse and day_rollover both high for one cycle.
- Load 24:10, then 12:60 → set_error pulses twice; time is unchanged.
- Time load of 05:00 in the same cycle as tick_min, from 10:30 → next value 05:00; no tick effect and no pulses.
- Alarm 06:00, alarm_en = 1, time 05:59, then tick → alarm = 1 at 06:00; alarm_ack for one cycle → alarm = 0 the next cycle. Repeat without ack → alarm clears after RING_TIMEOUT_MIN (= 5) further ticks, at 06:05.
- Assert rst_n low while alarm = 1 at 14:22 → all outputs go to their reset values immediately; set_ready returns 1 one edge after release.
